decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Registered, parametrised instruction-decode pipeline stage for the 16-bit CPU. Sits between
//  fetch and the register file/ALU, with valid/ready handshakes on both sides. Adds illegal-opcode
//  flagging, flush, and an optional register scoreboard that stalls on RAW/WAW hazards.
// PARAMETERS
//  INSTR_W     16  instruction width
//  REG_ADDR_W  3   register-specifier width (2**REG_ADDR_W registers)
//  DATA_W      16  width of zero-extended immediate output
//  IMM_W       INSTR_W-5-2*REG_ADDR_W (localparam, 5 at defaults) immediate field width
// PORTS
//  clk        in  1           clock, all state on rising edge
//  rst        in  1           synchronous reset, active-high
//  in_valid   in  1           fetch presents instruction
//  in_ready   out 1           stage accepts instruction this cycle
//  in_instr   in  INSTR_W     {op[3:0], setcc, rD, rA, rB/imm...}; imm = low IMM_W bits
//  out_valid  out 1           decoded bundle valid
//  out_ready  in  1           execute accepts bundle
//  out_unary, out_imm, out_setcc, out_wben  out 1  decoded controls
//  out_aluop  out 3           ALU code (0 = NOP)
//  out_rd, out_ra, out_rb     out REG_ADDR_W  register specifiers
//  out_immval out DATA_W      immediate, zero-extended
//  out_illegal out 1          bundle carries an undefined opcode
//  flush      in  1           kill held bundle and block acceptance this cycle
//  wb_valid   in  1           writeback retires a write to wb_rd
//  wb_rd      in  REG_ADDR_W  writeback destination
//  busy       out 1           stall due to scoreboard hazard
// BEHAVIOUR
//  - Reset: out_valid=0, all out_* controls/fields 0, busy=0, scoreboard cleared.
//  - Latency 1: bundle accepted on cycle N (in_valid&&in_ready) appears with out_valid on N+1.
//  - in_ready = !flush && !hazard && (!out_valid || out_ready). Issue = out_valid && out_ready.
//  - Held bundle stable while out_valid && !out_ready. flush: out_valid<=0 next cycle; flush beats in_valid.
//  - Opcodes: 0 ADD, 1 ADDI, 2 MOV, 3 MOVI, 4 SUB, 5 SUBI, 6 SHL, 7 SHLI, 8 SHLR, 9 SHLRI,
//    A AND, B ANDI, C OR, D ORI, E NOT; odd opcodes set out_imm. ALU codes: ADD=1 (MOV/MOVI also 1),
//    SUB=2, SHL=3, SHLR=4, AND=5, OR=6, NOT=7.
//  - MOV, MOVI, NOT: out_unary=1. out_setcc=instr bit INSTR_W-5. out_wben=1 for legal ops.
//  - Opcode F: out_illegal=1, out_wben=0, out_aluop=0, out_setcc=0; still handshaked.
//  - Unused fields (rB for imm ops, immval for reg ops) driven 0, never X.
//  - Source use: rA read unless MOVI; rB read only if !imm && !unary.
// CONFIGURATION
//  DECODE_SCOREBOARD_EN defined:
//   - pending[r] set on issue of bundle with out_wben, cleared on wb_valid for wb_rd.
//   - Set and clear of same reg in same cycle: set wins.
//   - hazard = in_valid && a used source or rD is in (pending | held out_rd when out_valid&&out_wben).
//   - Hazard uses registered pending, no writeback bypass. busy = hazard.
//  Undefined: hazard=0, busy=0; wb_valid/wb_rd ignored. Ports always present.
// STRUCTURE
//  - decode_pkg: opcode constants, ALU codes, field-position/width functions of INSTR_W/REG_ADDR_W.
//  - Sub-module decode_scoreboard (pending vector, set/clear, hazard compare), instantiated
//    only under DECODE_SCOREBOARD_EN.
//  - Combinational decode feeds a single output register.
// TESTING
//  1 ADDI r3<-r2+5 (16'h1345), out_ready=1 -> next cycle out_imm=1, aluop=1, rd=3, ra=2, immval=5, wben=1.
//  2 Opcode F instr -> out_illegal=1, wben=0, aluop=0, out_valid=1 for one handshake.
//  3 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, bundle stable, then one issue, no drop/dup.
//  4 flush with in_valid=1 and held bundle -> out_valid=0 next cycle, instr not accepted, in_ready=0.
//  5 [EN] ADD r1 issues, then SUB r4<-r1-r2 -> busy=1 until wb_valid wb_rd=1; accepted cycle after wb.
//  6 [EN] wb_valid wb_rd=1 same cycle as issue of new r1 writer -> pending[1] stays 1.
//  Also check: reset mid-stall -> all outputs 0, scoreboard empty next cycle.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared definitions for the 16-bit CPU decode stage: opcode and ALU encodings
// plus helpers that locate each instruction field from INSTR_W and REG_ADDR_W.
// Instruction layout, MSB first: {op, setcc, rD, rA, rB/imm}. The immediate
// occupies the low bits, and rB sits at the top of the immediate field.
package decode_pkg;

   localparam int OP_W = 4;

   typedef enum logic [3:0] {
      OP_ADD     = 4'h0,
      OP_ADDI    = 4'h1,
      OP_MOV     = 4'h2,
      OP_MOVI    = 4'h3,
      OP_SUB     = 4'h4,
      OP_SUBI    = 4'h5,
      OP_SHL     = 4'h6,
      OP_SHLI    = 4'h7,
      OP_SHLR    = 4'h8,
      OP_SHLRI   = 4'h9,
      OP_AND     = 4'hA,
      OP_ANDI    = 4'hB,
      OP_OR      = 4'hC,
      OP_ORI     = 4'hD,
      OP_NOT     = 4'hE,
      OP_ILLEGAL = 4'hF
   } opcode_e;

   typedef enum logic [2:0] {
      ALU_NOP  = 3'd0,
      ALU_ADD  = 3'd1,
      ALU_SUB  = 3'd2,
      ALU_SHL  = 3'd3,
      ALU_SHLR = 3'd4,
      ALU_AND  = 3'd5,
      ALU_OR   = 3'd6,
      ALU_NOT  = 3'd7
   } aluop_e;

   function automatic int opLsb(input int instrW);
      return instrW - OP_W;
   endfunction

   function automatic int setccBit(input int instrW);
      return instrW - OP_W - 1;
   endfunction

   function automatic int rdLsb(input int instrW, input int regW);
      return instrW - OP_W - 1 - regW;
   endfunction

   function automatic int raLsb(input int instrW, input int regW);
      return instrW - OP_W - 1 - 2 * regW;
   endfunction

   function automatic int immWidth(input int instrW, input int regW);
      return instrW - OP_W - 1 - 2 * regW;
   endfunction

   function automatic int rbLsb(input int instrW, input int regW);
      return immWidth(instrW, regW) - regW;
   endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Register scoreboard for the decode stage. Tracks destination registers of
// issued-but-not-retired writes and flags a hazard when the incoming
// instruction reads or rewrites one of them, or the register of the bundle
// currently held in the output stage.
module decode_scoreboard
#(
   parameter int REG_ADDR_W = 3
)(
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_issue,
   input  logic [REG_ADDR_W-1:0] i_issueRd,
   input  logic                  i_wbValid,
   input  logic [REG_ADDR_W-1:0] i_wbRd,
   input  logic                  i_inValid,
   input  logic                  i_useRa,
   input  logic [REG_ADDR_W-1:0] i_ra,
   input  logic                  i_useRb,
   input  logic [REG_ADDR_W-1:0] i_rb,
   input  logic                  i_useRd,
   input  logic [REG_ADDR_W-1:0] i_rd,
   input  logic                  i_heldValid,
   input  logic [REG_ADDR_W-1:0] i_heldRd,
   output logic                  o_hazard
);

   localparam int NREG = 2 ** REG_ADDR_W;

   logic [NREG-1:0] r_pending;
   logic [NREG-1:0] w_setMask;
   logic [NREG-1:0] w_clrMask;
   logic [NREG-1:0] w_blocked;

   // Build set/clear masks and compare the incoming specifiers against the
   // registered pending set plus the held writer; writeback is not bypassed.
   always_comb begin
      w_setMask = '0;
      w_clrMask = '0;
      w_blocked = r_pending;
      if (i_issue) w_setMask[i_issueRd] = 1'b1;
      if (i_wbValid) w_clrMask[i_wbRd] = 1'b1;
      if (i_heldValid) w_blocked[i_heldRd] = 1'b1;
      o_hazard = i_inValid &&
                 ((i_useRa && w_blocked[i_ra]) ||
                  (i_useRb && w_blocked[i_rb]) ||
                  (i_useRd && w_blocked[i_rd]));
   end

   // Pending update: a new issue to a register beats a retire of that register.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_pending <= '0;
      else       r_pending <= (r_pending & ~w_clrMask) | w_setMask;
   end

endmodule

// File: rtl/decode_stage.sv
// Registered instruction-decode stage with valid/ready on both sides,
// illegal-opcode flagging and flush. Defining DECODE_SCOREBOARD_EN adds the
// register scoreboard that stalls on RAW/WAW hazards; without it busy is 0
// and the writeback inputs are ignored.
module decode_stage
#(
   parameter int INSTR_W    = 16,
   parameter int REG_ADDR_W = 3,
   parameter int DATA_W     = 16
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [INSTR_W-1:0]    in_instr,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_unary,
   output logic                  out_imm,
   output logic                  out_setcc,
   output logic                  out_wben,
   output logic [2:0]            out_aluop,
   output logic [REG_ADDR_W-1:0] out_rd,
   output logic [REG_ADDR_W-1:0] out_ra,
   output logic [REG_ADDR_W-1:0] out_rb,
   output logic [DATA_W-1:0]     out_immval,
   output logic                  out_illegal,
   input  logic                  flush,
   input  logic                  wb_valid,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   output logic                  busy
);

   import decode_pkg::*;

   localparam int IMM_W     = immWidth(INSTR_W, REG_ADDR_W);
   localparam int OP_LSB    = opLsb(INSTR_W);
   localparam int SETCC_BIT = setccBit(INSTR_W);
   localparam int RD_LSB    = rdLsb(INSTR_W, REG_ADDR_W);
   localparam int RA_LSB    = raLsb(INSTR_W, REG_ADDR_W);
   localparam int RB_LSB    = rbLsb(INSTR_W, REG_ADDR_W);

   opcode_e               w_op;
   aluop_e                w_aluOp;
   logic                  w_illegal;
   logic                  w_unary;
   logic                  w_imm;
   logic                  w_setcc;
   logic                  w_wben;
   logic [REG_ADDR_W-1:0] w_rd;
   logic [REG_ADDR_W-1:0] w_ra;
   logic [REG_ADDR_W-1:0] w_rb;
   logic [DATA_W-1:0]     w_immVal;
   logic                  w_useRa;
   logic                  w_useRb;
   logic                  w_hazard;
   logic                  w_inReady;
   logic                  w_accept;
   logic                  w_issue;

   logic                  r_outValid;
   logic                  r_unary;
   logic                  r_imm;
   logic                  r_setcc;
   logic                  r_wben;
   logic [2:0]            r_aluOp;
   logic [REG_ADDR_W-1:0] r_rd;
   logic [REG_ADDR_W-1:0] r_ra;
   logic [REG_ADDR_W-1:0] r_rb;
   logic [DATA_W-1:0]     r_immVal;
   logic                  r_illegal;

   // Decode the incoming instruction; undefined opcodes carry only the
   // illegal flag and every unused field is forced to zero.
   always_comb begin
      w_op      = opcode_e'(in_instr[OP_LSB +: OP_W]);
      w_aluOp   = ALU_NOP;
      w_illegal = 1'b0;
      w_unary   = 1'b0;
      w_imm     = 1'b0;
      w_setcc   = 1'b0;
      w_wben    = 1'b0;
      w_rd      = '0;
      w_ra      = '0;
      w_rb      = '0;
      w_immVal  = '0;
      w_useRa   = 1'b0;
      w_useRb   = 1'b0;
      if (w_op == OP_ILLEGAL) begin
         w_illegal = 1'b1;
      end else begin
         w_imm   = in_instr[OP_LSB];
         w_setcc = in_instr[SETCC_BIT];
         w_wben  = 1'b1;
         w_rd    = in_instr[RD_LSB +: REG_ADDR_W];
         w_ra    = in_instr[RA_LSB +: REG_ADDR_W];
         w_unary = (w_op == OP_MOV) || (w_op == OP_MOVI) || (w_op == OP_NOT);
         case (w_op)
            OP_ADD, OP_ADDI, OP_MOV, OP_MOVI: w_aluOp = ALU_ADD;
            OP_SUB, OP_SUBI:                  w_aluOp = ALU_SUB;
            OP_SHL, OP_SHLI:                  w_aluOp = ALU_SHL;
            OP_SHLR, OP_SHLRI:                w_aluOp = ALU_SHLR;
            OP_AND, OP_ANDI:                  w_aluOp = ALU_AND;
            OP_OR, OP_ORI:                    w_aluOp = ALU_OR;
            OP_NOT:                           w_aluOp = ALU_NOT;
            default:                          w_aluOp = ALU_NOP;
         endcase
         if (w_imm) w_immVal[IMM_W-1:0] = in_instr[IMM_W-1:0];
         else       w_rb = in_instr[RB_LSB +: REG_ADDR_W];
         w_useRa = (w_op != OP_MOVI);
         w_useRb = !w_imm && !w_unary;
      end
   end

   assign w_inReady = !flush && !w_hazard && (!r_outValid || out_ready);
   assign w_accept  = in_valid && w_inReady;
   assign w_issue   = r_outValid && out_ready;

`ifdef DECODE_SCOREBOARD_EN
   decode_scoreboard #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_scoreboard (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_issue     (w_issue && r_wben),
      .i_issueRd   (r_rd),
      .i_wbValid   (wb_valid),
      .i_wbRd      (wb_rd),
      .i_inValid   (in_valid),
      .i_useRa     (w_useRa),
      .i_ra        (w_ra),
      .i_useRb     (w_useRb),
      .i_rb        (w_rb),
      .i_useRd     (w_wben),
      .i_rd        (w_rd),
      .i_heldValid (r_outValid && r_wben),
      .i_heldRd    (r_rd),
      .o_hazard    (w_hazard)
   );
`else
   logic w_unusedScoreboard;
   assign w_unusedScoreboard = ^{wb_valid, wb_rd, w_useRa, w_useRb, w_issue};
   assign w_hazard = 1'b0;
`endif

   // Output register: reset clears everything, flush drops the held bundle,
   // an accepted instruction loads, and an issue with nothing behind it empties.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_outValid <= 1'b0;
         r_unary    <= 1'b0;
         r_imm      <= 1'b0;
         r_setcc    <= 1'b0;
         r_wben     <= 1'b0;
         r_aluOp    <= '0;
         r_rd       <= '0;
         r_ra       <= '0;
         r_rb       <= '0;
         r_immVal   <= '0;
         r_illegal  <= 1'b0;
      end else if (flush) begin
         r_outValid <= 1'b0;
      end else if (w_accept) begin
         r_outValid <= 1'b1;
         r_unary    <= w_unary;
         r_imm      <= w_imm;
         r_setcc    <= w_setcc;
         r_wben     <= w_wben;
         r_aluOp    <= w_aluOp;
         r_rd       <= w_rd;
         r_ra       <= w_ra;
         r_rb       <= w_rb;
         r_immVal   <= w_immVal;
         r_illegal  <= w_illegal;
      end else if (out_ready) begin
         r_outValid <= 1'b0;
      end
   end

   assign in_ready    = w_inReady;
   assign busy        = w_hazard;
   assign out_valid   = r_outValid;
   assign out_unary   = r_unary;
   assign out_imm     = r_imm;
   assign out_setcc   = r_setcc;
   assign out_wben    = r_wben;
   assign out_aluop   = r_aluOp;
   assign out_rd      = r_rd;
   assign out_ra      = r_ra;
   assign out_rb      = r_rb;
   assign out_immval  = r_immVal;
   assign out_illegal = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage. Expected bundles are queued when the
// stage accepts an instruction and compared when the bundle issues.
// Scoreboard-specific scenarios run only when DECODE_SCOREBOARD_EN is defined.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_instr;
   logic        out_valid;
   logic        out_ready;
   logic        out_unary;
   logic        out_imm;
   logic        out_setcc;
   logic        out_wben;
   logic [2:0]  out_aluop;
   logic [2:0]  out_rd;
   logic [2:0]  out_ra;
   logic [2:0]  out_rb;
   logic [15:0] out_immval;
   logic        out_illegal;
   logic        flush;
   logic        wb_valid;
   logic [2:0]  wb_rd;
   logic        busy;

   int          nCompared   = 0;
   int          nMismatched = 0;
   logic [39:0] expQ[$];
   logic [39:0] expHead;

   decode_stage #(
      .INSTR_W    (16),
      .REG_ADDR_W (3),
      .DATA_W     (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_unary   (out_unary),
      .out_imm     (out_imm),
      .out_setcc   (out_setcc),
      .out_wben    (out_wben),
      .out_aluop   (out_aluop),
      .out_rd      (out_rd),
      .out_ra      (out_ra),
      .out_rb      (out_rb),
      .out_immval  (out_immval),
      .out_illegal (out_illegal),
      .flush       (flush),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .busy        (busy)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [39:0] observed, input logic [39:0] expected);
      nCompared++;
      if (observed !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [39:0] observedBundle();
      return {7'b0, out_illegal, out_unary, out_imm, out_setcc, out_wben,
              out_aluop, out_rd, out_ra, out_rb, out_immval};
   endfunction

   // Reference decode written from the opcode table.
   function automatic logic [39:0] modelDecode(input logic [15:0] instr);
      logic [3:0]  op;
      logic        ill, un, im, sc, wb;
      logic [2:0]  alu, rd, ra, rb;
      logic [15:0] iv;
      op  = instr[15:12];
      ill = 1'b0; un = 1'b0; im = 1'b0; sc = 1'b0; wb = 1'b0;
      alu = 3'd0; rd = 3'd0; ra = 3'd0; rb = 3'd0; iv = 16'd0;
      if (op == 4'hF) begin
         ill = 1'b1;
      end else begin
         case (op)
            4'h0, 4'h1, 4'h2, 4'h3: alu = 3'd1;
            4'h4, 4'h5:             alu = 3'd2;
            4'h6, 4'h7:             alu = 3'd3;
            4'h8, 4'h9:             alu = 3'd4;
            4'hA, 4'hB:             alu = 3'd5;
            4'hC, 4'hD:             alu = 3'd6;
            default:                alu = 3'd7;
         endcase
         im = (op == 4'h1) || (op == 4'h3) || (op == 4'h5) || (op == 4'h7) ||
              (op == 4'h9) || (op == 4'hB) || (op == 4'hD);
         un = (op == 4'h2) || (op == 4'h3) || (op == 4'hE);
         sc = instr[11];
         wb = 1'b1;
         rd = instr[10:8];
         ra = instr[7:5];
         if (im) iv = {11'b0, instr[4:0]};
         else    rb = instr[4:2];
      end
      return {7'b0, ill, un, im, sc, wb, alu, rd, ra, rb, iv};
   endfunction

   // Monitor: compare issued bundles, drop flushed ones, queue accepted ones.
   always @(negedge clk) begin
      if (rst) begin
         expQ.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpectedIssue", 40'(1), 40'(0));
            end else begin
               expHead = expQ.pop_front();
               checkOutput("bundle", observedBundle(), expHead);
            end
         end else if (out_valid && flush) begin
            if (expQ.size() != 0) expHead = expQ.pop_front();
         end
         if (in_valid && in_ready) expQ.push_back(modelDecode(in_instr));
      end
   end

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [15:0] instr);
      bit accepted;
      accepted = 1'b0;
      in_valid = 1'b1;
      in_instr = instr;
      for (int i = 0; i < 20 && !accepted; i++) begin
         @(negedge clk);
         accepted = in_ready;
         nextCycle();
      end
      in_valid = 1'b0;
      if (!accepted) checkOutput("acceptTimeout", 40'(0), 40'(1));
   endtask

   task automatic clearRegs();
      for (int r = 0; r < 8; r++) begin
         wb_valid = 1'b1;
         wb_rd    = 3'(r);
         nextCycle();
      end
      wb_valid = 1'b0;
      wb_rd    = 3'd0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_instr = 16'h0; out_ready = 1'b1;
      flush = 1'b0; wb_valid = 1'b0; wb_rd = 3'd0;
      repeat (2) nextCycle();
      @(negedge clk);
      checkOutput("resetValid", 40'(out_valid), 40'(0));
      checkOutput("resetBundle", observedBundle(), 40'(0));
      checkOutput("resetBusy", 40'(busy), 40'(0));
      nextCycle();
      rst = 1'b0;

      // ADDI r3 <- r2 + 5
      applyStimulus(16'h1345);
      @(negedge clk);
      checkOutput("addiValid", 40'(out_valid), 40'(1));
      checkOutput("addiFields", 40'({out_imm, out_aluop, out_rd, out_ra, out_immval, out_wben}),
                  40'({1'b1, 3'd1, 3'd3, 3'd2, 16'd5, 1'b1}));
      nextCycle();

      // Undefined opcode
      applyStimulus(16'hF123);
      @(negedge clk);
      checkOutput("illegalFields", 40'({out_valid, out_illegal, out_wben, out_aluop}),
                  40'({1'b1, 1'b1, 1'b0, 3'd0}));
      nextCycle();
      @(negedge clk);
      checkOutput("illegalOneShot", 40'(out_valid), 40'(0));
      nextCycle();
      clearRegs();

      // Backpressure: ADD r1 held, SUBI r5 waits three cycles
      out_ready = 1'b0;
      applyStimulus(16'h094C);
      in_valid = 1'b1;
      in_instr = 16'h55C7;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("stallReady", 40'(in_ready), 40'(0));
         checkOutput("stallValid", 40'(out_valid), 40'(1));
         checkOutput("stallHeld", observedBundle(), modelDecode(16'h094C));
         nextCycle();
      end
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("stallRelease", 40'(in_ready), 40'(1));
      nextCycle();
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("stallNext", 40'({out_valid, out_rd, out_rb, out_immval}),
                  40'({1'b1, 3'd5, 3'd0, 16'd7}));
      nextCycle();
      @(negedge clk);
      checkOutput("stallNoDup", 40'(out_valid), 40'(0));
      nextCycle();
      clearRegs();

      // Flush with a held bundle and a new instruction offered
      out_ready = 1'b0;
      applyStimulus(16'h1345);
      in_valid = 1'b1;
      in_instr = 16'h094C;
      flush    = 1'b1;
      @(negedge clk);
      checkOutput("flushReady", 40'(in_ready), 40'(0));
      nextCycle();
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("flushValid", 40'(out_valid), 40'(0));
      nextCycle();
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("flushNotAccepted", 40'(out_valid), 40'(0));
      nextCycle();
      clearRegs();

`ifdef DECODE_SCOREBOARD_EN
      // RAW: SUB r4 <- r1 - r2 behind ADD r1
      applyStimulus(16'h094C);
      in_valid = 1'b1;
      in_instr = 16'h4428;
      @(negedge clk);
      checkOutput("rawBusyHeld", 40'({busy, in_ready}), 40'({1'b1, 1'b0}));
      nextCycle();
      @(negedge clk);
      checkOutput("rawBusyPending", 40'(busy), 40'(1));
      nextCycle();
      wb_valid = 1'b1;
      wb_rd    = 3'd1;
      @(negedge clk);
      checkOutput("rawNoBypass", 40'(busy), 40'(1));
      nextCycle();
      wb_valid = 1'b0;
      @(negedge clk);
      checkOutput("rawReleased", 40'({busy, in_ready}), 40'({1'b0, 1'b1}));
      nextCycle();
      in_valid = 1'b0;
      nextCycle();
      clearRegs();

      // Retire and new issue of r1 in the same cycle
      out_ready = 1'b0;
      applyStimulus(16'h1141);
      out_ready = 1'b1;
      wb_valid  = 1'b1;
      wb_rd     = 3'd1;
      nextCycle();
      wb_valid = 1'b0;
      in_valid = 1'b1;
      in_instr = 16'h4428;
      @(negedge clk);
      checkOutput("setWins", 40'(busy), 40'(1));
      nextCycle();
      wb_valid = 1'b1;
      wb_rd    = 3'd1;
      nextCycle();
      wb_valid = 1'b0;
      @(negedge clk);
      checkOutput("setWinsRelease", 40'(in_ready), 40'(1));
      nextCycle();
      in_valid = 1'b0;
      nextCycle();
      clearRegs();
`endif

      // Reset while stalled with a pending writer and a waiting reader
      applyStimulus(16'h094C);
      nextCycle();
      out_ready = 1'b0;
      applyStimulus(16'h1345);
      in_valid = 1'b1;
      in_instr = 16'h4428;
      repeat (2) nextCycle();
      rst = 1'b1;
      nextCycle();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midResetValid", 40'(out_valid), 40'(0));
      checkOutput("midResetBundle", observedBundle(), 40'(0));
      checkOutput("midResetBusy", 40'({busy, in_ready}), 40'({1'b0, 1'b1}));
      nextCycle();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) nextCycle();
      checkOutput("drain", 40'(expQ.size()), 40'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
